ctrl_fsm_mc: RTL
================

Name: ctrl_fsm_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle accumulator-CPU controller.
- Sequences each instruction through FETCH, DECODE and EXECUTE, driving the datapath load/select strobes from a registered state.
- Adds a sticky halt, taken/not-taken branch handling, run gating and a retired-instruction counter.
- Sits between the instruction register/flag logic and the PC/accumulator/register-file/ALU datapath.

Parameters:
- OPC_W, 4: opcode width. Bits above [3:0] must be zero for a valid opcode; otherwise the opcode is unassigned.
- ALU_SEL_W, 4: SelALU width. Encodings are zero-extended to this width.
- ACC_SEL_W, 2: SelAcc width.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- CLB  in  1  reset, asynchronous, active-high.
- run  in  1  level; leaves IDLE when high.
- Opcode  in  OPC_W  from instruction register; valid from the DECODE cycle onward.
- Z  in  1  zero flag; sampled at the DECODE->EXECUTE edge.
- C  in  1  carry flag; sampled at the DECODE->EXECUTE edge.
- LoadIR  out  1  load instruction register.
- IncPC  out  1  PC increment.
- SelPC  out  1  PC source: 1 = register, 0 = immediate.
- LoadPC  out  1  PC parallel load.
- LoadReg  out  1  register-file write.
- LoadAcc  out  1  accumulator load.
- SelAcc  out  ACC_SEL_W  accumulator source: 0 = ALU, 1 = reg, 2 = imm.
- SelALU  out  ALU_SEL_W  ALU op/shift select.
- Halted  out  1  in HALT state.
- InstrCount  out  CNT_W  retired instructions.

Behaviour:
- Reset (CLB high, asynchronous): state = IDLE, InstrCount = 0, all strobes and selects = 0, Halted = 0. Reset mid-instruction aborts the instruction with no strobe issued.
- States: IDLE, FETCH, DECODE, EXECUTE, HALT. The state is encoded as a 3-bit register.
- IDLE: outputs 0. Goes to FETCH when run = 1; otherwise stays.
- FETCH: LoadIR = 1 for exactly one cycle, then DECODE.
- DECODE: all strobes 0. The opcode and the Z/C flags are captured. Always goes to EXECUTE.
- EXECUTE: the opcode-specific strobes are asserted for exactly one cycle. Then:
  - FETCH if run = 1;
  - IDLE if run = 0;
  - HALT for opcode 0xF.
- HALT: Halted = 1, all strobes 0. Only reset exits HALT; run is ignored.
- All outputs are registered and are valid in the cycle of the state they belong to. Each instruction takes 3 cycles.

EXECUTE decode, as {SelALU, SelAcc, LoadAcc, LoadReg, LoadPC, SelPC, IncPC}. Unlisted fields are 0.
- 0x0 NOP: IncPC = 1.
- 0x1 ADD: SelALU = 1000, LoadAcc = 1, IncPC = 1.
- 0x2 SUB: SelALU = 1100, LoadAcc = 1, IncPC = 1.
- 0x3 NOR: SelALU = 0100, LoadAcc = 1, IncPC = 1.
- 0xB SHL: SelALU = 0001, LoadAcc = 1, IncPC = 1.
- 0xC SHR: SelALU = 0011, LoadAcc = 1, IncPC = 1.
- 0x4 MOV rs: SelAcc = 01, LoadAcc = 1, IncPC = 1.
- 0x5 MOV rd: LoadReg = 1, IncPC = 1.
- 0xD LDI: SelAcc = 10, LoadAcc = 1, IncPC = 1.
- 0x6 JZ reg / 0x7 JZ imm: if captured Z = 1, then LoadPC = 1 and SelPC = 1 for reg, 0 for imm. If Z = 0, then IncPC = 1 (not-taken advances the PC).
- 0x8 JC reg / 0xA JC imm: same as JZ, using captured C.
- 0xF HALT: no strobes.
- 0x9, 0xE and any opcode with nonzero upper bits are unassigned and behave as NOP.

Invariants:
- LoadPC and IncPC are never both 1.
- No more than one of LoadAcc and LoadReg is 1.

InstrCount:
- Increments by 1 at the end of every EXECUTE, HALT included.
- Wraps from 2^CNT_W-1 to 0.
- Does not count instructions aborted by reset.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: adds output Illegal (1 bit, reset 0).
  - An unassigned opcode in EXECUTE issues no strobes, sets Illegal = 1 (sticky), goes to HALT, and increments InstrCount.
  - Only reset clears Illegal.
- Undefined: no Illegal port; unassigned opcodes are NOPs as described above.

Decomposition:
- Package ctrl_pkg:
  - state encoding constants;
  - opcode constants (OP_NOP ... OP_HALT);
  - ALU select constants (ALU_ADD = 1000, ALU_SUB = 1100, ALU_NOR = 0100, ALU_SHL = 0001, ALU_SHR = 0011);
  - SelAcc constants (ACC_ALU, ACC_REG, ACC_IMM).
- One natural sub-module: ctrl_decode. It is combinational: opcode + captured Z/C -> EXECUTE strobe vector. The FSM registers its result on entry to EXECUTE.

Test Plan:
- Reset then run = 1, Opcode = 0x1 -> LoadIR = 1 in cycle 1; in cycle 3, SelALU = 1000, LoadAcc = 1, IncPC = 1; InstrCount = 1 after cycle 3.
- Opcode = 0x7 with Z = 1 captured -> EXECUTE gives LoadPC = 1, SelPC = 0, IncPC = 0. Repeat with Z = 0 -> IncPC = 1, LoadPC = 0.
- Opcode = 0x8 with C = 1 -> LoadPC = 1, SelPC = 1. Toggling C after the DECODE edge does not change the EXECUTE strobes.
- Opcode = 0xF -> Halted = 1 from the next cycle. Holding run = 1 and changing Opcode for 10 cycles gives no strobes. Pulsing CLB mid-cycle returns all outputs to 0 and InstrCount to 0 immediately.
- CNT_W = 4: execute 17 NOPs -> InstrCount reads 1. Set run = 0 in EXECUTE -> FSM goes to IDLE and LoadIR stays 0.
- With CTRL_ILLEGAL_TRAP_EN, Opcode = 0x9 -> no strobes, Illegal = 1, Halted = 1. Without the macro, the same stimulus gives IncPC = 1 and continues.

Source files
------------

// File: rtl/ctrl_fsm_mc_pkg.sv
// rtl/ctrl_fsm_mc_pkg.sv - ctrl_pkg: state encoding, opcodes and datapath select constants
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_NOR    = 4'h3;
    localparam logic [3:0] OP_MOV_RS = 4'h4;
    localparam logic [3:0] OP_MOV_RD = 4'h5;
    localparam logic [3:0] OP_JZ_REG = 4'h6;
    localparam logic [3:0] OP_JZ_IMM = 4'h7;
    localparam logic [3:0] OP_JC_REG = 4'h8;
    localparam logic [3:0] OP_JC_IMM = 4'hA;
    localparam logic [3:0] OP_SHL    = 4'hB;
    localparam logic [3:0] OP_SHR    = 4'hC;
    localparam logic [3:0] OP_LDI    = 4'hD;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'b1000;
    localparam logic [3:0] ALU_SUB = 4'b1100;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0001;
    localparam logic [3:0] ALU_SHR = 4'b0011;

    localparam logic [1:0] ACC_ALU = 2'd0;
    localparam logic [1:0] ACC_REG = 2'd1;
    localparam logic [1:0] ACC_IMM = 2'd2;

    // Register-sourced jumps select the PC register path (SelPC = 1).
    function automatic logic isJumpReg(input logic [3:0] op);
        return (op == OP_JZ_REG) || (op == OP_JC_REG);
    endfunction

endpackage

// File: rtl/ctrl_fsm_mc_if.sv
// rtl/ctrl_fsm_mc_if.sv - controller bus; Illegal present only with CTRL_ILLEGAL_TRAP_EN
interface ctrl_fsm_mc_if #(
    parameter int OPC_W     = 4,
    parameter int ALU_SEL_W = 4,
    parameter int ACC_SEL_W = 2,
    parameter int CNT_W     = 16
);
    logic                 run;
    logic [OPC_W-1:0]     Opcode;
    logic                 Z;
    logic                 C;
    logic                 LoadIR;
    logic                 IncPC;
    logic                 SelPC;
    logic                 LoadPC;
    logic                 LoadReg;
    logic                 LoadAcc;
    logic [ACC_SEL_W-1:0] SelAcc;
    logic [ALU_SEL_W-1:0] SelALU;
    logic                 Halted;
    logic [CNT_W-1:0]     InstrCount;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                 Illegal;
`endif

    modport master (
        output run, Opcode, Z, C,
        input  LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU, Halted, InstrCount
`ifdef CTRL_ILLEGAL_TRAP_EN
        , input Illegal
`endif
    );

    modport slave (
        input  run, Opcode, Z, C,
        output LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU, Halted, InstrCount
`ifdef CTRL_ILLEGAL_TRAP_EN
        , output Illegal
`endif
    );

endinterface

// File: rtl/ctrl_fsm_mc_decode.sv
// rtl/ctrl_fsm_mc_decode.sv - ctrl_decode: opcode + flags to EXECUTE strobes (CTRL_ILLEGAL_TRAP_EN traps unassigned)
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W     = 4,
    parameter int ALU_SEL_W = 4,
    parameter int ACC_SEL_W = 2
) (
    input  logic [OPC_W-1:0]     Opcode,
    input  logic                 Z,
    input  logic                 C,
    output logic                 IncPC,
    output logic                 SelPC,
    output logic                 LoadPC,
    output logic                 LoadReg,
    output logic                 LoadAcc,
    output logic [ACC_SEL_W-1:0] SelAcc,
    output logic [ALU_SEL_W-1:0] SelALU,
    output logic                 isHalt
`ifdef CTRL_ILLEGAL_TRAP_EN
    , output logic               isIllegal
`endif
);

    logic [3:0] op;
    logic       upperZero;
    logic       taken;
    logic       unassigned;

    // Map the opcode to its strobe set; unassigned codes fall back to NOP or trap.
    always_comb begin
        IncPC      = 1'b0;
        SelPC      = 1'b0;
        LoadPC     = 1'b0;
        LoadReg    = 1'b0;
        LoadAcc    = 1'b0;
        SelAcc     = '0;
        SelALU     = '0;
        isHalt     = 1'b0;
        taken      = 1'b0;
        unassigned = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        isIllegal  = 1'b0;
`endif
        op        = Opcode[3:0];
        upperZero = ((Opcode >> 4) == '0);

        if (!upperZero) begin
            unassigned = 1'b1;
        end else begin
            case (op)
                OP_NOP:    IncPC = 1'b1;
                OP_ADD:    begin SelALU = ALU_SEL_W'(ALU_ADD); LoadAcc = 1'b1; IncPC = 1'b1; end
                OP_SUB:    begin SelALU = ALU_SEL_W'(ALU_SUB); LoadAcc = 1'b1; IncPC = 1'b1; end
                OP_NOR:    begin SelALU = ALU_SEL_W'(ALU_NOR); LoadAcc = 1'b1; IncPC = 1'b1; end
                OP_SHL:    begin SelALU = ALU_SEL_W'(ALU_SHL); LoadAcc = 1'b1; IncPC = 1'b1; end
                OP_SHR:    begin SelALU = ALU_SEL_W'(ALU_SHR); LoadAcc = 1'b1; IncPC = 1'b1; end
                OP_MOV_RS: begin SelAcc = ACC_SEL_W'(ACC_REG); LoadAcc = 1'b1; IncPC = 1'b1; end
                OP_LDI:    begin SelAcc = ACC_SEL_W'(ACC_IMM); LoadAcc = 1'b1; IncPC = 1'b1; end
                OP_MOV_RD: begin LoadReg = 1'b1; IncPC = 1'b1; end
                OP_JZ_REG, OP_JZ_IMM, OP_JC_REG, OP_JC_IMM: begin
                    taken  = (op == OP_JZ_REG || op == OP_JZ_IMM) ? Z : C;
                    LoadPC = taken;
                    SelPC  = taken && isJumpReg(op);
                    IncPC  = !taken;
                end
                OP_HALT:   isHalt = 1'b1;
                default:   unassigned = 1'b1;
            endcase
        end

        if (unassigned) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            isHalt    = 1'b1;
            isIllegal = 1'b1;
`else
            IncPC     = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/ctrl_fsm_mc.sv
// rtl/ctrl_fsm_mc.sv - multi-cycle accumulator-CPU controller; optional CTRL_ILLEGAL_TRAP_EN
module ctrl_fsm_mc
    import ctrl_pkg::*;
#(
    parameter int OPC_W     = 4,
    parameter int ALU_SEL_W = 4,
    parameter int ACC_SEL_W = 2,
    parameter int CNT_W     = 16
) (
    input logic          clk,
    input logic          CLB,
    ctrl_fsm_mc_if.slave bus
);

    state_t               state, stateNext;
    logic                 loadIR, incPC, selPC, loadPC, loadReg, loadAcc, halted;
    logic                 loadIRNext, incPCNext, selPCNext, loadPCNext, loadRegNext, loadAccNext, haltedNext;
    logic [ACC_SEL_W-1:0] selAcc, selAccNext;
    logic [ALU_SEL_W-1:0] selALU, selALUNext;
    logic [CNT_W-1:0]     instrCount, countNext;
    logic                 haltPending;

    logic                 decIncPC, decSelPC, decLoadPC, decLoadReg, decLoadAcc, decHalt;
    logic [ACC_SEL_W-1:0] decSelAcc;
    logic [ALU_SEL_W-1:0] decSelALU;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                 decIllegal, illegalPending, illegal, illegalNext;
`endif

    ctrl_decode #(
        .OPC_W    (OPC_W),
        .ALU_SEL_W(ALU_SEL_W),
        .ACC_SEL_W(ACC_SEL_W)
    ) u_decode (
        .Opcode   (bus.Opcode),
        .Z        (bus.Z),
        .C        (bus.C),
        .IncPC    (decIncPC),
        .SelPC    (decSelPC),
        .LoadPC   (decLoadPC),
        .LoadReg  (decLoadReg),
        .LoadAcc  (decLoadAcc),
        .SelAcc   (decSelAcc),
        .SelALU   (decSelALU),
        .isHalt   (decHalt)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .isIllegal(decIllegal)
`endif
    );

    // Next state, and the outputs belonging to that next state so they can be registered.
    always_comb begin
        stateNext   = state;
        loadIRNext  = 1'b0;
        incPCNext   = 1'b0;
        selPCNext   = 1'b0;
        loadPCNext  = 1'b0;
        loadRegNext = 1'b0;
        loadAccNext = 1'b0;
        selAccNext  = '0;
        selALUNext  = '0;
        haltedNext  = 1'b0;
        countNext   = instrCount;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegalNext = illegal;
`endif

        case (state)
            ST_IDLE:    if (bus.run) stateNext = ST_FETCH;
            ST_FETCH:   stateNext = ST_DECODE;
            ST_DECODE:  stateNext = ST_EXECUTE;
            ST_EXECUTE: begin
                countNext = instrCount + CNT_W'(1);
                if (haltPending)  stateNext = ST_HALT;
                else if (bus.run) stateNext = ST_FETCH;
                else              stateNext = ST_IDLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegalNext = illegal | illegalPending;
`endif
            end
            ST_HALT:    stateNext = ST_HALT;
            default:    stateNext = ST_IDLE;
        endcase

        case (stateNext)
            ST_FETCH:   loadIRNext = 1'b1;
            ST_EXECUTE: begin
                incPCNext   = decIncPC;
                selPCNext   = decSelPC;
                loadPCNext  = decLoadPC;
                loadRegNext = decLoadReg;
                loadAccNext = decLoadAcc;
                selAccNext  = decSelAcc;
                selALUNext  = decSelALU;
            end
            ST_HALT:    haltedNext = 1'b1;
            default:    ;
        endcase
    end

    // State and registered strobes; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            state   <= ST_IDLE;
            loadIR  <= 1'b0;
            incPC   <= 1'b0;
            selPC   <= 1'b0;
            loadPC  <= 1'b0;
            loadReg <= 1'b0;
            loadAcc <= 1'b0;
            selAcc  <= '0;
            selALU  <= '0;
            halted  <= 1'b0;
        end else begin
            state   <= stateNext;
            loadIR  <= loadIRNext;
            incPC   <= incPCNext;
            selPC   <= selPCNext;
            loadPC  <= loadPCNext;
            loadReg <= loadRegNext;
            loadAcc <= loadAccNext;
            selAcc  <= selAccNext;
            selALU  <= selALUNext;
            halted  <= haltedNext;
        end
    end

    // Retired counter, plus the halt/trap decision latched with the flags at the DECODE->EXECUTE edge.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            instrCount     <= '0;
            haltPending    <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegalPending <= 1'b0;
            illegal        <= 1'b0;
`endif
        end else begin
            instrCount <= countNext;
            if (state == ST_DECODE) begin
                haltPending    <= decHalt;
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegalPending <= decIllegal;
`endif
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal <= illegalNext;
`endif
        end
    end

    assign bus.LoadIR     = loadIR;
    assign bus.IncPC      = incPC;
    assign bus.SelPC      = selPC;
    assign bus.LoadPC     = loadPC;
    assign bus.LoadReg    = loadReg;
    assign bus.LoadAcc    = loadAcc;
    assign bus.SelAcc     = selAcc;
    assign bus.SelALU     = selALU;
    assign bus.Halted     = halted;
    assign bus.InstrCount = instrCount;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.Illegal    = illegal;
`endif

endmodule
